// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, strobe width and error codes.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   localparam int unsigned StrbW = 4;

   typedef enum logic [1:0] {
      ErrNone     = 2'd0,
      ErrMisalign = 2'd1,
      ErrRange    = 2'd2
   } err_e;

   // Classifies a byte address against a window of depth words starting at base.
   function automatic err_e addr_err(logic [31:0] addr, logic [31:0] base, int unsigned depth);
      logic [32:0] span;
      logic [31:0] off;
      span = 33'(depth) << 2;
      off  = addr - base;
      if (addr[1:0] != 2'b00) return ErrMisalign;
      if ({1'b0, off} >= span) return ErrRange;
      return ErrNone;
   endfunction

endpackage

// File: rtl/dmem_responder_sram_bank.sv
// Word-wide storage with per-byte write enables and a registered read port that
// returns zero on cycles without a read.
module sram_bank #(
   parameter int unsigned Depth = 1024,
   localparam int unsigned Aw   = $clog2(Depth)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic          re_i,
   input  logic [Aw-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [Depth];
   logic [31:0] rdata_q, rdata_d;

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i && be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
   end

   always_comb begin
      rdata_d = re_i ? mem_q[addr_i] : 32'h0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rdata_q <= 32'h0;
      else         rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one access at a time, inserts WAIT_CYCLES of
// latency, commits or reads the array on the edge entering RESP and stalls the pipeline meanwhile.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        stall
);

   localparam int unsigned Aw       = $clog2(DEPTH);
   localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [StrbW-1:0]  wstrb_q, wstrb_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic              accept, enter_resp, acc_bad, acc_we;
   logic [StrbW-1:0]  acc_wstrb;
   logic [31:0]       acc_addr, acc_wdata;

   // With zero wait states RESP is entered on the accept edge, so the live request is used.
   always_comb begin
      accept    = ready_q & req_valid;
      acc_we    = (state_q == StIdle) ? req_we    : we_q;
      acc_wstrb = (state_q == StIdle) ? req_wstrb : wstrb_q;
      acc_addr  = (state_q == StIdle) ? req_addr  : addr_q;
      acc_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
      acc_bad   = (addr_err(acc_addr, BASE_ADDR, DEPTH) != ErrNone);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      wstrb_d = wstrb_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               we_d    = req_we;
               wstrb_d = req_wstrb;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = WaitLoad;
               state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      enter_resp = (state_d == StResp) && (state_q != StResp);
      err_d      = enter_resp & acc_bad;
      ready_d    = (state_d == StIdle);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         wstrb_q <= '0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         we_q    <= we_d;
         wstrb_q <= wstrb_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // BASE_ADDR is DEPTH*4 aligned, so the word index is just the low address bits.
   sram_bank #(
      .Depth (DEPTH)
   ) u_sram_bank (
      .clk_i   (clk),
      .rst_ni  (rst),
      .we_i    (enter_resp & acc_we & ~acc_bad),
      .be_i    (acc_wstrb),
      .re_i    (enter_resp & ~acc_we & ~acc_bad),
      .addr_i  (acc_addr[2 +: Aw]),
      .wdata_i (acc_wdata),
      .rdata_o (resp_rdata)
   );

   assign req_ready  = ready_q;
   assign resp_valid = (state_q == StResp);
   assign resp_err   = err_q;
   assign stall      = accept | (state_q == StWait);

endmodule
